// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hilo_muldiv_pkg : op encodings, FSM states and EX-side decode helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
package hilo_muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'h0;
  localparam logic [3:0] OP_MULTU = 4'h1;
  localparam logic [3:0] OP_DIV   = 4'h2;
  localparam logic [3:0] OP_DIVU  = 4'h3;
  localparam logic [3:0] OP_MADD  = 4'h4;
  localparam logic [3:0] OP_MADDU = 4'h5;
  localparam logic [3:0] OP_MSUB  = 4'h6;
  localparam logic [3:0] OP_MSUBU = 4'h7;
  localparam logic [3:0] OP_MTHI  = 4'h8;
  localparam logic [3:0] OP_MTLO  = 4'h9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // EX stalls a HI/LO consumer while the unit is busy
  function automatic logic uses_hilo(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hilo_muldiv : multi-cycle multiply/divide/accumulate unit with HI/LO regs.
// Rev 1.0
// ---------------------------------------------------------------------------
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   phi_q, phi_d, plo_q, plo_d;
  logic               pwe_q, pwe_d;

  logic               signed_op;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, mul_res;
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    signed_op = is_signed_op(op);
    a_ext = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    // Sign-extended operands make the truncated product correct for both signednesses
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    case (op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase

    // Divide on magnitudes, then fix signs; most-negative / -1 falls out naturally
    a_neg    = signed_op & a[WIDTH-1];
    b_neg    = signed_op & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwe_d   = pwe_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (is_mul_op(op)) begin
            {phi_d, plo_d} = mul_res;
            pwe_d   = 1'b1;
            cnt_d   = MULT_N;
            state_d = ST_RUN;
          end else if (is_div_op(op)) begin
            phi_d   = rem;
            plo_d   = quo;
            pwe_d   = !div_zero;
            cnt_d   = DIV_N;
            state_d = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pwe_d   = 1'b0;
        end else if (cnt_q == CNT_ONE) begin
          if (pwe_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
          pwe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwe_q   <= pwe_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hilo_muldiv : directed + randomized bench against an arithmetic model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MC;
      OP_DIV, OP_DIVU: return DC;
      default: return 0;
    endcase
  endfunction

  // Architectural effect of one op, from plain 64-bit arithmetic
  task automatic model(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     acc, ps, pu;
    sa = $signed(xa);
    sb = $signed(xb);
    ua = xa;
    ub = xb;
    acc = {m_hi, m_lo};
    ps = sa * sb;
    pu = ua * ub;
    case (o)
      OP_MULT:  {m_hi, m_lo} = ps;
      OP_MULTU: {m_hi, m_lo} = pu;
      OP_MADD:  {m_hi, m_lo} = acc + ps;
      OP_MADDU: {m_hi, m_lo} = acc + pu;
      OP_MSUB:  {m_hi, m_lo} = acc - ps;
      OP_MSUBU: {m_hi, m_lo} = acc - pu;
      OP_DIV: if (xb != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      OP_DIVU: if (xb != 0) begin
        m_lo = 32'(ua / ub);
        m_hi = 32'(ua % ub);
      end
      OP_MTHI: m_hi = xa;
      OP_MTLO: m_lo = xa;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
    model(o, xa, xb);
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles(o)));
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'h0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
    check("mult_lo_const", {32'h0, lo}, 64'hFFFF_FFEB);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu");
    check("divu_lo_const", {32'h0, lo}, 64'd14);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_const", {32'h0, lo}, 64'h8000_0000);

    run_op(OP_MTHI, 32'd1, 32'd0, "mthi");
    run_op(OP_MTLO, 32'd0, 32'd0, "mtlo");
    run_op(OP_MADD, 32'd2, 32'd3, "madd");
    check("madd_hi_const", {32'h0, hi}, 64'd1);
    run_op(OP_MSUBU, 32'd7, 32'd1, "msubu");
    check("msubu_lo_const", {32'h0, lo}, 64'hFFFF_FFFF);

    run_op(OP_MTHI, 32'h1234_5678, 32'd0, "mthi2");
    run_op(OP_MTLO, 32'h1234_5678, 32'd0, "mtlo2");
    run_op(OP_DIV, 32'd55, 32'd0, "div0");
    check("div0_hi_const", {32'h0, hi}, 64'h1234_5678);

    // Cancel on the third busy cycle of a MULT
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'h0, busy}, 64'h0);
    repeat (MC + 2) @(negedge clk);
    check("cancel_hi", {32'h0, hi}, {32'h0, m_hi});
    check("cancel_lo", {32'h0, lo}, {32'h0, m_lo});

    // MTLO issued while busy must be dropped
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd11; b = 32'd13;
    @(negedge clk);
    op = OP_MTLO; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    model(OP_MULTU, 32'd11, 32'd13);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_mtlo_cycles", 64'(cyc), 64'(MC - 1));
    check("busy_mtlo_lo", {32'h0, lo}, {32'h0, m_lo});

    // start together with cancel in IDLE
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = OP_MTHI; a = 32'hAAAA_5555;
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_busy", {63'h0, busy}, 64'h0);
    repeat (MC + 1) @(negedge clk);
    check("idle_cancel_hi", {32'h0, hi}, {32'h0, m_hi});
    check("idle_cancel_lo", {32'h0, lo}, {32'h0, m_lo});

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), "rand");
    end

    // Reset mid-DIV after making HI/LO nonzero
    run_op(OP_MTHI, 32'h0BAD_F00D, 32'd0, "pre_rst_hi");
    run_op(OP_MTLO, 32'h0000_0F0F, 32'd0, "pre_rst_lo");
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_hi", {32'h0, hi}, 64'h0);
    check("midrst_lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (DC + 2) @(negedge clk);
    check("post_rst_lo", {32'h0, lo}, 64'h0);
    run_op(OP_MULT, 32'd6, 32'd7, "post_rst_mult");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
